// File: rtl/pulse_pkg.sv
// Shared definitions for both ends of the serial pulse link.
// Frame length default lives here so generator and receiver agree.
package pulse_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int PULSE_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/sync_bit_counter.sv
// Purpose: mod-WIDTH bit counter with synchronous clear and count enable.
// Latency: count updates on the edge after clr/en; term decodes the current count.
// Backpressure: none; en stalls the count, clr has priority over en.
module sync_bit_counter #(
    parameter int WIDTH = 8,
    parameter int CW    = $clog2(WIDTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] count,
    output logic          term
);

    assign term = (count == CW'(WIDTH - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= term ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/pulse_receiver8.sv
// Purpose: capture a WIDTH-bit serial frame after start, flag it with valid and a pattern match.
// Latency: data/valid/match appear WIDTH cycles after the start edge; valid lasts one cycle.
// Backpressure: none; start is ignored mid-frame and accepted again in the valid cycle.
module pulse_receiver8
    import pulse_pkg::*;
#(
    parameter int WIDTH     = PULSE_WIDTH_DEFAULT,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sin,
    input  logic             start,
    input  logic [WIDTH-1:0] pattern,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    output logic             match,
    output logic             busy
);

    localparam int CW = $clog2(WIDTH);

    state_t           state;
    logic [WIDTH-1:0] sh;
    logic [WIDTH-1:0] sh_next;
    logic             cnt_clr;
    logic             cnt_en;
    logic             cnt_term;
    logic [CW-1:0]    bit_idx_unused;

    assign cnt_clr = start && (state != SHIFT);
    assign cnt_en  = (state == SHIFT);

    sync_bit_counter #(
        .WIDTH (WIDTH),
        .CW    (CW)
    ) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .count (bit_idx_unused),
        .term  (cnt_term)
    );

    // The completing edge loads data from the shifted value so the last bit is included.
    always_comb begin
        sh_next = sh;
        if (MSB_FIRST) begin
            sh_next = {sh[WIDTH-2:0], sin};
        end else begin
            sh_next = {sin, sh[WIDTH-1:1]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            sh    <= '0;
            data  <= '0;
            match <= 1'b0;
        end else begin
            // DONE lasts one cycle, so clearing here keeps match confined to it.
            match <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    sh <= sh_next;
                    if (cnt_term) begin
                        data  <= sh_next;
                        match <= (sh_next == pattern);
                        state <= DONE;
                    end
                end
                DONE: begin
                    state <= start ? SHIFT : IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy  = (state == SHIFT);
    assign valid = (state == DONE);

endmodule
